// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite SRAM slave with byte-lane writes and programmable wait states.
// Define AHB_SRAM_ERR_EN to answer out-of-range, oversize or misaligned transfers with a two-cycle ERROR.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no data phase in flight, hreadyout=1, may accept
// ST_WAIT  | data phase stalled, hreadyout=0, wait_cnt counting down
// ST_DATA  | data phase completes, read data driven / write commits
// ST_ERR1  | first ERROR cycle, hreadyout=0, hresp=1
// ST_ERR2  | second ERROR cycle, hreadyout=1, hresp=1, may accept
module ahb_sram_slave #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic              hready,
  input  logic [DATA_W-1:0] hwdata,
  output logic [DATA_W-1:0] hrdata,
  output logic              hreadyout,
  output logic              hresp
);

  localparam int NBYTES = DATA_W / 8;
  localparam int LANE_W = $clog2(NBYTES);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int OFF_W  = IDX_W + LANE_W;
  localparam logic [2:0]      SIZE_FULL = 3'(LANE_W);
  localparam logic [3:0]      WS        = 4'(WAIT_STATES);
  localparam logic [LANE_W:0] LANE_ONE  = (LANE_W+1)'(1);

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t             state;
  logic [OFF_W-1:0]   addr_q;
  logic               write_q;
  logic [2:0]         size_q;
  logic [3:0]         wait_cnt;
  logic               hreadyout_q;
  logic               hresp_q;
  logic [DATA_W-1:0]  rdata_hold;
  logic [DATA_W-1:0]  mem [MEM_DEPTH];

  logic               accept;
  logic               xfer_err;
  logic               rd_active;
  logic               wr_commit;
  logic [IDX_W-1:0]   word_idx;
  logic [NBYTES-1:0]  byte_en;
  logic [LANE_W-1:0]  lane_base;
  logic [LANE_W:0]    lane_cnt;
  logic               unused_bits;

  assign unused_bits = ^{htrans[0], haddr[ADDR_W-1:OFF_W]};

  // A new address phase is only taken while this slave is itself ready.
  assign accept    = hsel & hready & htrans[1] & hreadyout_q;
  assign word_idx  = addr_q[OFF_W-1:LANE_W];
  assign rd_active = (state == ST_DATA) && !write_q;
  assign wr_commit = (state == ST_DATA) && write_q && !hreset;

`ifdef AHB_SRAM_ERR_EN
  logic range_err;
  logic size_err;
  logic align_err;

  always_comb begin
    range_err = (haddr >> OFF_W) != '0;
    size_err  = hsize > SIZE_FULL;
    align_err = 1'b0;
    for (int i = 0; i < LANE_W; i++) begin
      if ((3'(i) < hsize) && haddr[i]) align_err = 1'b1;
    end
    xfer_err = range_err | size_err | align_err;
  end
`else
  assign xfer_err = 1'b0;
`endif

  // Lane window is aligned down to the transfer size; oversize means whole word.
  always_comb begin
    byte_en   = '0;
    lane_cnt  = '0;
    lane_base = '0;
    if (size_q >= SIZE_FULL) begin
      byte_en = '1;
    end else begin
      lane_cnt  = LANE_ONE << size_q;
      lane_base = addr_q[LANE_W-1:0] & ~(LANE_W'(lane_cnt) - 1'b1);
      for (int i = 0; i < NBYTES; i++) begin
        byte_en[i] = (LANE_W'(i) >= lane_base) &&
                     ({1'b0, LANE_W'(i)} < ({1'b0, lane_base} + lane_cnt));
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state       <= ST_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      wait_cnt    <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= '0;
    end else begin
      case (state)
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state       <= ST_DATA;
            hreadyout_q <= 1'b1;
          end
        end
        ST_ERR1: begin
          state       <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        default: begin
          state       <= ST_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b0;
          if (accept) begin
            addr_q   <= haddr[OFF_W-1:0];
            write_q  <= hwrite;
            size_q   <= hsize;
            wait_cnt <= WS;
            if (xfer_err) begin
              state       <= ST_ERR1;
              write_q     <= 1'b0;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state       <= ST_WAIT;
              hreadyout_q <= 1'b0;
            end else begin
              state <= ST_DATA;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge hclk) begin
    if (wr_commit) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      rdata_hold <= '0;
    end else if (rd_active) begin
      rdata_hold <= mem[word_idx];
    end
  end

  assign hrdata    = rd_active ? mem[word_idx] : rdata_hold;
  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed checks of ahb_sram_slave with zero and three wait states.
// Honours AHB_SRAM_ERR_EN when computing expected responses.
module tb_ahb_sram_slave;

  localparam logic [1:0] TR_IDLE = 2'b00;
  localparam logic [1:0] TR_BUSY = 2'b01;
  localparam logic [1:0] TR_NSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ  = 2'b11;
`ifdef AHB_SRAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  logic        hclk   = 1'b0;
  logic        hreset = 1'b1;
  logic        hsel0  = 1'b0;
  logic        hsel3  = 1'b0;
  logic [31:0] haddr  = '0;
  logic [1:0]  htrans = TR_IDLE;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize  = 3'd2;
  logic [31:0] hwdata = '0;
  logic [31:0] hrdata0, hrdata3;
  logic        hreadyout0, hreadyout3, hresp0, hresp3;

  int checks   = 0;
  int failures = 0;

  always #5 hclk = ~hclk;

  ahb_sram_slave #(.WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hready(hreadyout0), .hwdata(hwdata),
    .hrdata(hrdata0), .hreadyout(hreadyout0), .hresp(hresp0)
  );

  ahb_sram_slave #(.WAIT_STATES(3)) u_dut3 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hready(hreadyout3), .hwdata(hwdata),
    .hrdata(hrdata3), .hreadyout(hreadyout3), .hresp(hresp3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one bus cycle after the rising edge, return at the falling edge for sampling.
  task automatic step(input logic s0, input logic s3, input logic [1:0] tr, input logic wr,
                      input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    @(posedge hclk);
    #1;
    hsel0  = s0;
    hsel3  = s3;
    htrans = tr;
    hwrite = wr;
    hsize  = sz;
    haddr  = a;
    hwdata = wd;
    @(negedge hclk);
  endtask

  // Single word transfer on the wait-state slave; counts stalled data-phase cycles.
  task automatic xfer3(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output int lows);
    step(1'b0, 1'b1, TR_NSEQ, wr, 3'd2, a, 32'h0);
    step(1'b0, 1'b0, TR_IDLE, 1'b0, 3'd2, 32'h0, wd);
    lows = 0;
    while (!hreadyout3 && lows < 20) begin
      lows++;
      @(negedge hclk);
    end
    rd = hrdata3;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[21];
    logic [31:0] rd;
    int lows;

    vecs[0]  = '{1'b1, TR_NSEQ, 1'b1, 3'd2, 32'h10, 32'h0,        1'b0, 32'h0};
    vecs[1]  = '{1'b1, TR_SEQ,  1'b0, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, TR_NSEQ, 1'b1, 3'd2, 32'h10, 32'h0,        1'b1, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, TR_NSEQ, 1'b1, 3'd0, 32'h11, 32'h11223344, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, TR_NSEQ, 1'b0, 3'd2, 32'h10, 32'h0000AA00, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, TR_NSEQ, 1'b1, 3'd2, 32'h14, 32'h0,        1'b1, 32'h1122AA44};
    vecs[6]  = '{1'b1, TR_NSEQ, 1'b1, 3'd1, 32'h16, 32'hA5A5A5A5, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, TR_NSEQ, 1'b0, 3'd2, 32'h14, 32'hBEEF0000, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, TR_BUSY, 1'b0, 3'd2, 32'h14, 32'h0,        1'b1, 32'hBEEFA5A5};
    vecs[9]  = '{1'b1, TR_IDLE, 1'b0, 3'd2, 32'h0,  32'h0,        1'b1, 32'hBEEFA5A5};
    vecs[10] = '{1'b1, TR_NSEQ, 1'b1, 3'd2, 32'h18, 32'h0,        1'b0, 32'h0};
    vecs[11] = '{1'b1, TR_BUSY, 1'b1, 3'd2, 32'h1C, 32'hCAFEF00D, 1'b0, 32'h0};
    vecs[12] = '{1'b1, TR_SEQ,  1'b0, 3'd2, 32'h18, 32'h0,        1'b0, 32'h0};
    vecs[13] = '{1'b1, TR_IDLE, 1'b0, 3'd2, 32'h0,  32'h0,        1'b1, 32'hCAFEF00D};
    vecs[14] = '{1'b0, TR_NSEQ, 1'b1, 3'd2, 32'h18, 32'h0,        1'b0, 32'h0};
    vecs[15] = '{1'b0, TR_NSEQ, 1'b0, 3'd2, 32'h18, 32'h12345678, 1'b1, 32'hCAFEF00D};
    vecs[16] = '{1'b1, TR_NSEQ, 1'b0, 3'd2, 32'h18, 32'h12345678, 1'b1, 32'hCAFEF00D};
    vecs[17] = '{1'b1, TR_IDLE, 1'b0, 3'd2, 32'h0,  32'h0,        1'b1, 32'hCAFEF00D};
    vecs[18] = '{1'b1, TR_NSEQ, 1'b1, 3'd0, 32'h1B, 32'h0,        1'b0, 32'h0};
    vecs[19] = '{1'b1, TR_NSEQ, 1'b0, 3'd2, 32'h18, 32'h77FFFFFF, 1'b0, 32'h0};
    vecs[20] = '{1'b1, TR_IDLE, 1'b0, 3'd2, 32'h0,  32'h0,        1'b1, 32'h77FEF00D};

    hreset = 1'b1;
    step(1'b0, 1'b0, TR_IDLE, 1'b0, 3'd2, 32'h0, 32'h0);
    step(1'b0, 1'b0, TR_IDLE, 1'b0, 3'd2, 32'h0, 32'h0);
    chk("rst_rdy0",   32'(hreadyout0), 32'd1);
    chk("rst_resp0",  32'(hresp0),     32'd0);
    chk("rst_rdata0", hrdata0,         32'h0);
    chk("rst_rdy3",   32'(hreadyout3), 32'd1);
    chk("rst_rdata3", hrdata3,         32'h0);
    hreset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      step(vecs[i].sel, 1'b0, vecs[i].trans, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wd);
      chk($sformatf("vec%0d_rdy", i),  32'(hreadyout0), 32'd1);
      chk($sformatf("vec%0d_resp", i), 32'(hresp0),     32'd0);
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), hrdata0, vecs[i].exp_rd);
    end

    // Out-of-range write: ERROR with the check enabled, wraps to word 0 otherwise.
    step(1'b1, 1'b0, TR_NSEQ, 1'b1, 3'd2, 32'h0, 32'h0);
    step(1'b1, 1'b0, TR_NSEQ, 1'b1, 3'd2, 32'h1000, 32'h01020304);
    chk("rng_addr_rdy", 32'(hreadyout0), 32'd1);
    step(1'b1, 1'b0, TR_IDLE, 1'b0, 3'd2, 32'h0, 32'h5A5A5A5A);
    chk("rng_p1_rdy",  32'(hreadyout0), ERR_EN ? 32'd0 : 32'd1);
    chk("rng_p1_resp", 32'(hresp0),     ERR_EN ? 32'd1 : 32'd0);
    step(1'b1, 1'b0, TR_IDLE, 1'b0, 3'd2, 32'h0, 32'h5A5A5A5A);
    chk("rng_p2_rdy",  32'(hreadyout0), 32'd1);
    chk("rng_p2_resp", 32'(hresp0),     ERR_EN ? 32'd1 : 32'd0);
    step(1'b1, 1'b0, TR_NSEQ, 1'b0, 3'd2, 32'h0, 32'h0);
    chk("rng_rd_resp", 32'(hresp0), 32'd0);
    step(1'b1, 1'b0, TR_IDLE, 1'b0, 3'd2, 32'h0, 32'h0);
    chk("rng_word0", hrdata0, ERR_EN ? 32'h01020304 : 32'h5A5A5A5A);

    // Misaligned word write at 0x02, then a read accepted straight out of ERR2.
    step(1'b1, 1'b0, TR_NSEQ, 1'b1, 3'd2, 32'h2, 32'h0);
    step(1'b1, 1'b0, TR_IDLE, 1'b0, 3'd2, 32'h0, 32'h99887766);
    chk("mis_p1_rdy",  32'(hreadyout0), ERR_EN ? 32'd0 : 32'd1);
    chk("mis_p1_resp", 32'(hresp0),     ERR_EN ? 32'd1 : 32'd0);
    step(1'b1, 1'b0, TR_NSEQ, 1'b0, 3'd2, 32'h0, 32'h99887766);
    chk("mis_p2_rdy",  32'(hreadyout0), 32'd1);
    chk("mis_p2_resp", 32'(hresp0),     ERR_EN ? 32'd1 : 32'd0);
    step(1'b1, 1'b0, TR_IDLE, 1'b0, 3'd2, 32'h0, 32'h0);
    chk("mis_word0", hrdata0, ERR_EN ? 32'h01020304 : 32'h99887766);
    chk("mis_rd_resp", 32'(hresp0), 32'd0);

    // Oversize (8-byte) write on a 32-bit slave.
    step(1'b1, 1'b0, TR_NSEQ, 1'b1, 3'd2, 32'h8, 32'h0);
    step(1'b1, 1'b0, TR_NSEQ, 1'b1, 3'd3, 32'h8, 32'h0BADCAFE);
    step(1'b1, 1'b0, TR_IDLE, 1'b0, 3'd2, 32'h0, 32'h11111111);
    chk("ovs_p1_rdy",  32'(hreadyout0), ERR_EN ? 32'd0 : 32'd1);
    chk("ovs_p1_resp", 32'(hresp0),     ERR_EN ? 32'd1 : 32'd0);
    step(1'b1, 1'b0, TR_NSEQ, 1'b0, 3'd2, 32'h8, 32'h11111111);
    chk("ovs_p2_resp", 32'(hresp0), ERR_EN ? 32'd1 : 32'd0);
    step(1'b1, 1'b0, TR_IDLE, 1'b0, 3'd2, 32'h0, 32'h0);
    chk("ovs_word2", hrdata0, ERR_EN ? 32'h0BADCAFE : 32'h11111111);

    // Three wait states: write then read back, each with exactly three stalled cycles.
    xfer3(1'b1, 32'h40, 32'h13579BDF, rd, lows);
    chk("ws3_wr_lows", 32'(lows), 32'd3);
    chk("ws3_wr_resp", 32'(hresp3), 32'd0);
    xfer3(1'b0, 32'h40, 32'h0, rd, lows);
    chk("ws3_rd_lows", 32'(lows), 32'd3);
    chk("ws3_rd_data", rd, 32'h13579BDF);

    // Reset during the wait window abandons the pending write.
    step(1'b0, 1'b1, TR_NSEQ, 1'b1, 3'd2, 32'h40, 32'h0);
    step(1'b0, 1'b0, TR_IDLE, 1'b0, 3'd2, 32'h0, 32'hFFFFFFFF);
    chk("mid_wait_rdy", 32'(hreadyout3), 32'd0);
    hreset = 1'b1;
    step(1'b0, 1'b0, TR_IDLE, 1'b0, 3'd2, 32'h0, 32'hFFFFFFFF);
    chk("mid_rst_rdy",   32'(hreadyout3), 32'd1);
    chk("mid_rst_resp",  32'(hresp3),     32'd0);
    chk("mid_rst_rdata", hrdata3,         32'h0);
    hreset = 1'b0;
    repeat (3) step(1'b0, 1'b0, TR_IDLE, 1'b0, 3'd2, 32'h0, 32'hFFFFFFFF);
    xfer3(1'b0, 32'h40, 32'hFFFFFFFF, rd, lows);
    chk("mid_rst_lows", 32'(lows), 32'd3);
    chk("mid_rst_mem",  rd, 32'h13579BDF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
